// File: rtl/spi_host_xfer.sv
// SPI mode-0 host for the register-slave frame: {rw,addr}, length, then N data bytes.
// Define SPI_HOST_BYTE_GAP_EN to insert BYTE_GAP idle SCK-low cycles between bytes.
module spi_host_xfer #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 4,
    parameter int BYTE_GAP = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic       i_rw,
    input  logic [6:0] i_addr,
    input  logic [7:0] i_len,
    input  logic [7:0] i_wr_data,
    input  logic       i_wr_valid,
    output logic       o_wr_ready,
    output logic [7:0] o_rd_data,
    output logic       o_rd_valid,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_spi_cs_n,
    output logic       o_spi_sck,
    output logic       o_spi_so,
    input  logic       i_spi_si
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SHIFT, S_GAP, S_LOAD, S_HOLD, S_GAPIDLE
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt, wait_lim, div_cnt;
    logic [2:0]  bit_cnt;
    logic [9:0]  byte_idx, last_idx;
    logic        rw_q;
    logic [7:0]  len_q;
    logic [6:0]  tx_sr, rx_sr;
    logic        wait_done, half_end, rise, fall, byte_end, is_last;
    logic        ld_point, ld_wdata, wr_hs;

    always_comb begin
        wait_lim = 16'd1;
        case (state)
            S_SETUP:   wait_lim = 16'(CS_SETUP);
            S_HOLD:    wait_lim = 16'(CS_HOLD);
            S_GAPIDLE: wait_lim = 16'(CS_IDLE);
            S_GAP:     wait_lim = 16'(BYTE_GAP);
            default:   wait_lim = 16'd1;
        endcase
    end

    assign wait_done = (cnt == wait_lim - 16'd1);
    assign half_end  = (div_cnt == 16'(CLK_DIV - 1));
    assign rise      = (state == S_SHIFT) && !o_spi_sck && half_end;
    assign fall      = (state == S_SHIFT) &&  o_spi_sck && half_end;
    assign byte_end  = fall && (bit_cnt == 3'd7);
    assign is_last   = (byte_idx == last_idx);
    assign wr_hs     = o_wr_ready && i_wr_valid;

`ifdef SPI_HOST_BYTE_GAP_EN
    // Write data is requested in the last gap cycle, after byte_idx has advanced.
    assign ld_point = (state == S_GAP) && wait_done;
    assign ld_wdata = rw_q && (byte_idx >= 10'd2);
`else
    // Write data is requested in the cycle of the previous byte's final SCK fall.
    assign ld_point = byte_end;
    assign ld_wdata = rw_q && (byte_idx != 10'd0) && !is_last;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (i_start) state_nxt = S_SETUP;
            S_SETUP:   if (wait_done) state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (byte_end) begin
                    if (is_last) begin
                        state_nxt = S_HOLD;
                    end else begin
`ifdef SPI_HOST_BYTE_GAP_EN
                        state_nxt = S_GAP;
`else
                        if (ld_wdata && !i_wr_valid) state_nxt = S_LOAD;
`endif
                    end
                end
            end
            S_GAP: begin
                if (wait_done) state_nxt = (ld_wdata && !i_wr_valid) ? S_LOAD : S_SHIFT;
            end
            S_LOAD:    if (i_wr_valid) state_nxt = S_SHIFT;
            S_HOLD:    if (wait_done) state_nxt = S_GAPIDLE;
            S_GAPIDLE: if (wait_done) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy     = (state != S_IDLE);
        o_wr_ready = (ld_point && ld_wdata) || (state == S_LOAD);
    end

    // tx_sr holds the bits still to be sent after the one already on o_spi_so.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_spi_cs_n <= 1'b1;
            o_spi_sck  <= 1'b0;
            o_spi_so   <= 1'b0;
            o_done     <= 1'b0;
            o_rd_valid <= 1'b0;
            o_rd_data  <= 8'd0;
            cnt        <= 16'd0;
            div_cnt    <= 16'd0;
            bit_cnt    <= 3'd0;
            byte_idx   <= 10'd0;
            last_idx   <= 10'd0;
        end else begin
            o_done     <= 1'b0;
            o_rd_valid <= 1'b0;
            cnt        <= (state_nxt != state) ? 16'd0 : cnt + 16'd1;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        rw_q       <= i_rw;
                        len_q      <= i_len;
                        last_idx   <= (i_len == 8'd0) ? 10'd257 : {2'b00, i_len} + 10'd1;
                        tx_sr      <= i_addr;
                        o_spi_so   <= i_rw;
                        o_spi_cs_n <= 1'b0;
                        byte_idx   <= 10'd0;
                        bit_cnt    <= 3'd0;
                        div_cnt    <= 16'd0;
                    end
                end
                S_SHIFT: begin
                    div_cnt <= half_end ? 16'd0 : div_cnt + 16'd1;
                    if (half_end) o_spi_sck <= ~o_spi_sck;
                    if (rise) begin
                        rx_sr <= {rx_sr[5:0], i_spi_si};
                        if (bit_cnt == 3'd7 && !rw_q && byte_idx >= 10'd2) begin
                            o_rd_data  <= {rx_sr, i_spi_si};
                            o_rd_valid <= 1'b1;
                        end
                    end
                    if (fall) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt != 3'd7) begin
                            o_spi_so <= tx_sr[6];
                            tx_sr    <= {tx_sr[5:0], 1'b0};
                        end else begin
                            byte_idx <= byte_idx + 10'd1;
                            if (byte_idx == 10'd0) begin
                                o_spi_so <= len_q[7];
                                tx_sr    <= len_q[6:0];
                            end else if (!rw_q) begin
                                o_spi_so <= 1'b0;
                                tx_sr    <= 7'd0;
                            end else if (wr_hs) begin
                                o_spi_so <= i_wr_data[7];
                                tx_sr    <= i_wr_data[6:0];
                            end
                        end
                    end
                end
                S_GAP, S_LOAD: begin
                    if (wr_hs) begin
                        o_spi_so <= i_wr_data[7];
                        tx_sr    <= i_wr_data[6:0];
                    end
                end
                S_HOLD: begin
                    if (wait_done) begin
                        o_spi_cs_n <= 1'b1;
                        o_spi_so   <= 1'b0;
                        o_done     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
